// File: rtl/alu.sv
// alu: registered RV32IM integer ALU for the execute stage.
//   Combinational compute of base-integer and M-extension ops, result and
//   zero flag registered on the rising clock edge (one-cycle latency, no stall).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (result=0, zero_flag=1)
//   ip1        operand A (rs1)
//   ip2        operand B (rs2 or immediate)
//   operation  5-bit op select
//   result     registered result
//   zero_flag  registered, 1 when result == 0
module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ip1,
  input  logic [XLEN-1:0] ip2,
  input  logic [4:0]      operation,
  output logic [XLEN-1:0] result,
  output logic            zero_flag
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b00001,
    OP_SLL    = 5'b00010,
    OP_SLT    = 5'b00011,
    OP_SLTU   = 5'b00100,
    OP_XOR    = 5'b00101,
    OP_SRL    = 5'b00110,
    OP_SRA    = 5'b00111,
    OP_OR     = 5'b01000,
    OP_AND    = 5'b01001,
    OP_MUL    = 5'b01010,
    OP_MULH   = 5'b01011,
    OP_MULHSU = 5'b01100,
    OP_MULHU  = 5'b01101,
    OP_DIV    = 5'b01110,
    OP_DIVU   = 5'b01111,
    OP_REM    = 5'b10000,
    OP_REMU   = 5'b10001
  } op_e;

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]   result_d, result_q;
  logic              zero_flag_d, zero_flag_q;

  logic [SHW-1:0]    shamt;
  logic              a_sext, b_sext;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic              div_signed, q_neg, r_neg, b_zero;
  logic [XLEN-1:0]   dvd, dvs, dvs_safe, quo, rem;

  assign shamt = ip2[SHW-1:0];

  // One shared 2*XLEN multiplier; operand extension picks the signedness.
  // The low half is signedness-independent, so MUL reuses it.
  always_comb begin
    a_sext = (operation == OP_MULH) || (operation == OP_MULHSU);
    b_sext = (operation == OP_MULH);
    mul_a  = {{XLEN{a_sext & ip1[XLEN-1]}}, ip1};
    mul_b  = {{XLEN{b_sext & ip2[XLEN-1]}}, ip2};
    prod   = mul_a * mul_b;
  end

  // One shared unsigned divider on magnitudes; signs are restored afterwards.
  // The signed overflow case (MIN / -1) falls out naturally: |MIN| = MIN,
  // quotient sign positive -> MIN, remainder 0.
  always_comb begin
    div_signed = (operation == OP_DIV) || (operation == OP_REM);
    b_zero     = (ip2 == '0);
    dvd        = (div_signed && ip1[XLEN-1]) ? (~ip1 + 1'b1) : ip1;
    dvs        = (div_signed && ip2[XLEN-1]) ? (~ip2 + 1'b1) : ip2;
    // Divisor forced nonzero so the operator never sees x/0; the real
    // divide-by-zero result is selected below.
    dvs_safe   = b_zero ? {{(XLEN-1){1'b0}}, 1'b1} : dvs;
    quo        = dvd / dvs_safe;
    rem        = dvd % dvs_safe;
    q_neg      = div_signed && (ip1[XLEN-1] ^ ip2[XLEN-1]);
    r_neg      = div_signed && ip1[XLEN-1];
  end

  always_comb begin
    result_d = '0;
    case (operation)
      OP_ADD:    result_d = ip1 + ip2;
      OP_SUB:    result_d = ip1 - ip2;
      OP_SLL:    result_d = ip1 << shamt;
      OP_SLT:    result_d = {{(XLEN-1){1'b0}}, ($signed(ip1) < $signed(ip2))};
      OP_SLTU:   result_d = {{(XLEN-1){1'b0}}, (ip1 < ip2)};
      OP_XOR:    result_d = ip1 ^ ip2;
      OP_SRL:    result_d = ip1 >> shamt;
      OP_SRA:    result_d = $unsigned($signed(ip1) >>> shamt);
      OP_OR:     result_d = ip1 | ip2;
      OP_AND:    result_d = ip1 & ip2;
      OP_MUL:    result_d = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = prod[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU:   result_d = b_zero ? '1  : (q_neg ? (~quo + 1'b1) : quo);
      OP_REM,
      OP_REMU:   result_d = b_zero ? ip1 : (r_neg ? (~rem + 1'b1) : rem);
      default:   result_d = '0;
    endcase
    zero_flag_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      zero_flag_q <= 1'b1;
    end else begin
      result_q    <= result_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_flag_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed scenarios plus randomized
// stimulus checked against a behavioural model built on 64-bit integer math.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] ip1, ip2;
  logic [4:0]  operation;
  logic [31:0] result;
  logic        zero_flag;

  int total = 0;
  int bad   = 0;

  alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ip1       (ip1),
    .ip2       (ip2),
    .operation (operation),
    .result    (result),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain signed/unsigned 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      5'd0:  w = ua + ub;
      5'd1:  w = ua - ub;
      5'd2:  w = ua << b[4:0];
      5'd3:  w = (sa < sb) ? 64'd1 : 64'd0;
      5'd4:  w = (ua < ub) ? 64'd1 : 64'd0;
      5'd5:  w = ua ^ ub;
      5'd6:  w = ua >> b[4:0];
      5'd7:  w = sa >>> b[4:0];
      5'd8:  w = ua | ub;
      5'd9:  w = ua & ub;
      5'd10: begin up = ua * ub; w = up; end
      5'd11: begin sp = sa * sb; w = sp >> 32; end
      5'd12: begin sp = sa * longint'(ub); w = sp >> 32; end
      5'd13: begin up = ua * ub; w = up >> 32; end
      5'd14: begin
        if (b == 0) w = 64'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = 64'h8000_0000;
        else begin sp = sa / sb; w = sp; end
      end
      5'd15: w = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
      5'd16: begin
        if (b == 0) w = ua;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) w = 0;
        else begin sp = sa % sb; w = sp; end
      end
      5'd17: w = (b == 0) ? ua : ua % ub;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Present inputs before the next rising edge, then sample 1ns after it.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op);
    rst = r; ip1 = a; ip2 = b; operation = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'd5, 32'd7, 5'd0);
    total++;
    if (result !== 32'd0 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL reset got=%h/%b exp=00000000/1", result, zero_flag);
    end
  endtask

  task automatic test_add();
    step(1'b0, 32'd23, 32'd46, 5'd0);
    total++;
    if (result !== 32'd69 || zero_flag !== 1'b0) begin
      bad++;
      $display("FAIL add got=%h/%b exp=00000045/0", result, zero_flag);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 32'd128, 32'd59, 5'd1);
    total++;
    if (result !== 32'd69) begin
      bad++;
      $display("FAIL sub got=%h exp=00000045", result);
    end
    step(1'b0, 32'd23, 32'd2, 5'd2);
    total++;
    if (result !== 32'd92) begin
      bad++;
      $display("FAIL sll got=%h exp=0000005c", result);
    end
  endtask

  task automatic test_divide();
    logic [31:0] a  [4] = '{32'd654, 32'd99, 32'd7, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd46, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [4:0]  op [4] = '{5'd17, 5'd15, 5'd16, 5'd14};
    logic [31:0] ex [4] = '{32'd10, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, a[i], b[i], op[i]);
      total++;
      if (result !== ex[i] || zero_flag !== (ex[i] == 0)) begin
        bad++;
        $display("FAIL divide[%0d] op=%0d got=%h/%b exp=%h", i, op[i], result, zero_flag, ex[i]);
      end
    end
    // Overflow remainder and signed divide by zero.
    step(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    total++;
    if (result !== 32'd0 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL rem_ovf got=%h/%b exp=00000000/1", result, zero_flag);
    end
    step(1'b0, 32'hFFFF_FFF9, 32'd0, 5'd14);
    total++;
    if (result !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_zero got=%h exp=ffffffff", result);
    end
  endtask

  task automatic test_logic();
    step(1'b0, 32'd1, 32'd1, 5'd9);
    total++;
    if (result !== 32'd1 || zero_flag !== 1'b0) begin
      bad++;
      $display("FAIL and got=%h/%b exp=00000001/0", result, zero_flag);
    end
    step(1'b0, 32'd0, 32'd1, 5'd8);
    total++;
    if (result !== 32'd1) begin
      bad++;
      $display("FAIL or got=%h exp=00000001", result);
    end
    step(1'b0, 32'd1, 32'd1, 5'd5);
    total++;
    if (result !== 32'd0 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL xor got=%h/%b exp=00000000/1", result, zero_flag);
    end
  endtask

  task automatic test_signed();
    logic [31:0] a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [5] = '{32'd1, 32'd1, 32'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [4:0]  op [5] = '{5'd3, 5'd4, 5'd7, 5'd13, 5'd11};
    logic [31:0] ex [5] = '{32'd1, 32'd0, 32'hC000_0000, 32'hFFFF_FFFE, 32'd0};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, a[i], b[i], op[i]);
      total++;
      if (result !== ex[i] || zero_flag !== (ex[i] == 0)) begin
        bad++;
        $display("FAIL signed[%0d] op=%0d got=%h/%b exp=%h", i, op[i], result, zero_flag, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 32'd1, 32'd2, 5'd0);
    step(1'b1, 32'd23, 32'd46, 5'd0);
    total++;
    if (result !== 32'd0 || zero_flag !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got=%h/%b exp=00000000/1", result, zero_flag);
    end
  endtask

  task automatic test_unused_ops();
    for (int op = 18; op < 32; op++) begin
      step(1'b0, $urandom | 32'd1, $urandom, 5'(op));
      total++;
      if (result !== 32'd0 || zero_flag !== 1'b1) begin
        bad++;
        $display("FAIL unused op=%0d got=%h/%b exp=00000000/1", op, result, zero_flag);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] spec [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
    logic [31:0] a, b, ex;
    logic [4:0]  op;
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(3) == 0) ? spec[$urandom_range(5)] : $urandom;
      b  = ($urandom_range(3) == 0) ? spec[$urandom_range(5)] : $urandom;
      if ($urandom_range(7) == 0) b = $urandom_range(300);
      op = 5'($urandom_range(17));
      ex = model(a, b, op);
      step(1'b0, a, b, op);
      total++;
      if (result !== ex || zero_flag !== (ex == 0)) begin
        bad++;
        $display("FAIL random op=%0d a=%h b=%h got=%h/%b exp=%h", op, a, b, result, zero_flag, ex);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ip1 = '0; ip2 = '0; operation = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_back_to_back();
    test_divide();
    test_logic();
    test_signed();
    test_reset_mid();
    test_unused_ops();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
